// File: rtl/fpu_div_seq_pkg.sv
// Shared definitions for the sequential single-precision divider.
// Holds the IEEE-754 constants, control-vector bit positions, FSM state
// encoding and an operand classifier used by the top level.
package fpu_div_seq_pkg;

  localparam logic [30:0] Inf  = 31'h7f800000;
  localparam logic [30:0] QNan = 31'h7fc00001;
  localparam logic [7:0]  Bias = 8'd127;

  // Bit positions in control = {inf,snan,qnan,ine,overflow,underflow,zero,div_by_zero}
  localparam int unsigned CtlInf  = 7;
  localparam int unsigned CtlSnan = 6;
  localparam int unsigned CtlQnan = 5;
  localparam int unsigned CtlIne  = 4;
  localparam int unsigned CtlOvf  = 3;
  localparam int unsigned CtlUnf  = 2;
  localparam int unsigned CtlZero = 1;
  localparam int unsigned CtlDbz  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StDiv,
    StRnd
  } state_e;

  typedef struct packed {
    logic zero;  // exponent 0, denormals included (flushed)
    logic inf;
    logic nan;
    logic snan;
  } fclass_t;

  function automatic fclass_t fclass(input logic [31:0] x);
    fclass_t c;
    c.zero = (x[30:23] == 8'h00);
    c.inf  = (x[30:23] == 8'hff) && (x[22:0] == 23'h0);
    c.nan  = (x[30:23] == 8'hff) && (x[22:0] != 23'h0);
    c.snan = c.nan && !x[22];
    return c;
  endfunction

endpackage

// File: rtl/div_r2_seq.sv
// Radix-2 restoring mantissa divider.
// Produces q = floor(ma * 2^(QBITS-1) / mb), one quotient bit per cycle.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         load ma/mb and begin (one-cycle pulse)
//   ma, mb        normalised 24-bit mantissas (hidden bit set)
//   q             quotient, valid once done has pulsed
//   rem_nz        final remainder non-zero (sticky contribution)
//   done          one-cycle pulse the cycle after the last quotient bit
module div_r2_seq #(
  parameter int unsigned QBITS = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [23:0]      ma,
  input  logic [23:0]      mb,
  output logic [QBITS-1:0] q,
  output logic             rem_nz,
  output logic             done
);

  localparam int unsigned CntW = $clog2(QBITS);

  logic [25:0]      rem_q, rem_d;
  logic [QBITS-1:0] q_q, q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [26:0]      diff;
  logic             ge;
  logic [25:0]      rem_sel;

  always_comb begin
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff    = {1'b0, rem_q} - {3'b000, mb};
    ge      = ~diff[26];
    rem_sel = ge ? diff[25:0] : rem_q;
    if (start) begin
      rem_d  = {2'b00, ma};
      q_d    = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      q_d = {q_q[QBITS-2:0], ge};
      if (cnt_q == CntW'(QBITS - 1)) begin
        // Keep the unshifted remainder so rem_nz reflects the true residue.
        rem_d  = rem_sel;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        rem_d = rem_sel << 1;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign q      = q_q;
  assign rem_nz = |rem_q;
  assign done   = done_q;

endmodule

// File: rtl/fpu_div_seq.sv
// Sequential IEEE-754 single-precision divider, out = opa / opb.
// Round-to-nearest-even only; denormal inputs and outputs flush to zero.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      opa/opb valid
//   in_ready      high only when idle; transfer on in_valid & in_ready
//   opa, opb      dividend, divisor
//   out_valid     one-cycle pulse with a new result
//   out, control  result and {inf,snan,qnan,ine,ovf,unf,zero,div_by_zero}, held
module fpu_div_seq
  import fpu_div_seq_pkg::*;
#(
  parameter int unsigned QBITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        out_valid,
  output logic [31:0] out,
  output logic [7:0]  control
);

  state_e             state_q, state_d;
  logic [31:0]        opa_q, opb_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [31:0]        out_q;
  logic [7:0]         control_q;
  logic               out_valid_q;

  logic               div_start;
  logic [QBITS-1:0]   q;
  logic               rem_nz;
  logic               div_done;

  fclass_t            ca, cb;
  logic               a_fin;
  logic [QBITS-1:0]   qn;
  logic signed [9:0]  e_norm, e_rnd;
  logic [23:0]        mant;
  logic               guard, sticky;
  logic [24:0]        mant_r;
  logic [31:0]        res;
  logic [7:0]         ctl;
  logic               unused_mant;

  assign div_start = (state_q == StSetup);

  div_r2_seq #(
    .QBITS(QBITS)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .ma    ({1'b1, opa_q[22:0]}),
    .mb    ({1'b1, opb_q[22:0]}),
    .q     (q),
    .rem_nz(rem_nz),
    .done  (div_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StSetup;
      StSetup: state_d = StDiv;
      StDiv:   if (div_done) state_d = StRnd;
      StRnd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Normalise, round and resolve special operands.
  always_comb begin
    ca    = fclass(opa_q);
    cb    = fclass(opb_q);
    a_fin = !ca.inf && !ca.nan;
    // q below 2^(QBITS-1) means ma < mb: shift up one place and drop the exponent.
    qn     = q[QBITS-1] ? q : {q[QBITS-2:0], 1'b0};
    e_norm = q[QBITS-1] ? exp_q : exp_q - 10'sd1;
    mant   = qn[QBITS-1 -: 24];
    guard  = qn[QBITS-25];
    sticky = (|qn[QBITS-26:0]) | rem_nz;
    mant_r = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    // A carry out leaves mant_r[22:0] all zero, so only the exponent moves.
    e_rnd  = e_norm + {9'd0, mant_r[24]};

    res         = {sign_q, e_rnd[7:0], mant_r[22:0]};
    ctl         = 8'h00;
    ctl[CtlIne] = guard | sticky;
    if (e_rnd >= 10'sd255) begin
      res          = {sign_q, Inf};
      ctl[CtlOvf]  = 1'b1;
      ctl[CtlInf]  = 1'b1;
      ctl[CtlIne]  = 1'b1;
    end else if (e_rnd <= 10'sd0) begin
      res          = {sign_q, 31'h0};
      ctl[CtlUnf]  = 1'b1;
      ctl[CtlZero] = 1'b1;
      ctl[CtlIne]  = 1'b1;
    end

    if (ca.nan || cb.nan) begin
      res          = {1'b0, QNan};
      ctl          = 8'h00;
      ctl[CtlQnan] = 1'b1;
      ctl[CtlSnan] = ca.snan | cb.snan;
    end else if ((ca.zero && cb.zero) || (ca.inf && cb.inf)) begin
      res          = {1'b0, QNan};
      ctl          = 8'h00;
      ctl[CtlQnan] = 1'b1;
    end else if (cb.zero && a_fin) begin
      res          = {sign_q, Inf};
      ctl          = 8'h00;
      ctl[CtlInf]  = 1'b1;
      ctl[CtlDbz]  = 1'b1;
    end else if (ca.inf) begin
      res          = {sign_q, Inf};
      ctl          = 8'h00;
      ctl[CtlInf]  = 1'b1;
    end else if (ca.zero || cb.inf) begin
      res          = {sign_q, 31'h0};
      ctl          = 8'h00;
      ctl[CtlZero] = 1'b1;
    end
  end

  assign unused_mant = mant_r[23];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      opa_q       <= '0;
      opb_q       <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      out_q       <= '0;
      control_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      if (state_q == StIdle && in_valid) begin
        opa_q <= opa;
        opb_q <= opb;
      end
      if (state_q == StSetup) begin
        sign_q <= opa_q[31] ^ opb_q[31];
        exp_q  <= {2'b00, opa_q[30:23]} - {2'b00, opb_q[30:23]} + {2'b00, Bias};
      end
      if (state_q == StRnd) begin
        out_q       <= res;
        control_q   <= ctl;
        out_valid_q <= 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign control   = control_q;

endmodule

// File: tb/tb_fpu_div_seq.sv
module tb_fpu_div_seq;

  localparam int Lat = 29;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] opa, opb;
  logic        out_valid;
  logic [31:0] out;
  logic [7:0]  control;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  bit          pend = 1'b0;
  int          due = 0;
  logic [39:0] pend_res;
  logic [31:0] exp_out = 32'h0;
  logic [7:0]  exp_ctl = 8'h0;
  bit          exp_rdy;

  fpu_div_seq #(
    .QBITS(26)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opa      (opa),
    .opb      (opb),
    .out_valid(out_valid),
    .out      (out),
    .control  (control)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact rational quotient, normalised to [1,2), rounded by
  // comparing twice the remainder against the divisor.
  function automatic logic [39:0] model(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e;
    logic [22:0] fa, fb;
    bit          za, zb, ia, ib, na, nb, s;
    longint      n, d, m, r;
    logic [7:0]  c;
    logic [7:0]  eb8;
    logic [22:0] fr;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    c  = 8'h00;
    if (na || nb) begin
      c[5] = 1'b1;
      c[6] = (na && !fa[22]) || (nb && !fb[22]);
      return {32'h7fc00001, c};
    end
    if ((za && zb) || (ia && ib)) return {32'h7fc00001, 8'h20};
    if (zb && !ia) return {s, 31'h7f800000, 8'h81};
    if (ia) return {s, 31'h7f800000, 8'h80};
    if (za || ib) return {s, 31'h0, 8'h02};
    n = 64'h800000 + longint'(fa);
    d = 64'h800000 + longint'(fb);
    e = ea - eb + 127;
    if (n < d) begin
      n = n * 2;
      e = e - 1;
    end
    m = (n * 64'd8388608) / d;
    r = (n * 64'd8388608) % d;
    if ((2 * r > d) || ((2 * r == d) && (m % 2 == 1))) m = m + 1;
    if (m == 64'd16777216) begin
      m = 64'd8388608;
      e = e + 1;
    end
    if (r != 0) c[4] = 1'b1;
    if (e >= 255) return {s, 31'h7f800000, 8'h98};
    if (e <= 0) return {s, 31'h0, 8'h16};
    eb8 = 8'(e);
    fr  = 23'(m);
    return {s, eb8, fr, c};
  endfunction

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [22:0] f;
    int          sel;
    s   = 1'($urandom);
    f   = 23'($urandom);
    sel = int'($urandom_range(0, 15));
    case (sel)
      0:       return {s, 31'h0};
      1:       return {s, 8'h00, f | 23'h1};
      2:       return {s, 8'hff, 23'h0};
      3:       return {s, 8'hff, 1'b1, f[21:0]};
      4:       return {s, 8'hff, 1'b0, f[21:1], 1'b1};
      5:       return {s, 8'h01, f};
      6:       return {s, 8'hfe, f};
      default: return {s, 8'($urandom_range(1, 254)), f};
    endcase
  endfunction

  // Compare process: tracks the one outstanding operation and checks every cycle.
  always @(negedge clk) begin
    if (rst) begin
      pend    = 1'b0;
      exp_out = 32'h0;
      exp_ctl = 8'h0;
      chk("rst in_ready", 64'(in_ready), 64'd1);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst out", 64'(out), 64'd0);
      chk("rst control", 64'(control), 64'd0);
    end else begin
      exp_rdy = !(pend && cyc < due);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (pend && cyc == due) begin
        exp_out = pend_res[39:8];
        exp_ctl = pend_res[7:0];
        pend    = 1'b0;
        chk("out_valid pulse", 64'(out_valid), 64'd1);
      end else begin
        chk("out_valid quiet", 64'(out_valid), 64'd0);
      end
      chk("out", 64'(out), 64'(exp_out));
      chk("control", 64'(control), 64'(exp_ctl));
      if (in_valid && exp_rdy) begin
        pend     = 1'b1;
        due      = cyc + 1 + Lat;
        pend_res = model(opa, opb);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    int n;
    opa      = a;
    opb      = b;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL accept timeout: in_ready low for %0d cycles, expected high", n);
    end
    @(posedge clk);
    #1;
    // Scribble operands while busy; they must not leak into the result.
    opa      = $urandom;
    opb      = $urandom;
    in_valid = 1'b0;
  endtask

  logic [31:0] va[8] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                         32'h00000000, 32'h7F800001, 32'h7F000000, 32'h00800000};
  logic [31:0] vb[8] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000,
                         32'h00000000, 32'h3F800000, 32'h3E800000, 32'h40000000};
  logic [39:0] ve[8] = '{{32'h40400000, 8'h00}, {32'h3EAAAAAB, 8'h10},
                         {32'h3F800000, 8'h00}, {32'hFF800000, 8'h81},
                         {32'h7FC00001, 8'h20}, {32'h7FC00001, 8'h60},
                         {32'h7F800000, 8'h98}, {32'h00000000, 8'h16}};

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    opa      = 32'h0;
    opb      = 32'h0;
    idle(3);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) chk($sformatf("model vec%0d", i), 64'(model(va[i], vb[i])),
                                    64'(ve[i]));

    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i]);
      idle(int'($urandom_range(0, 35)));
    end

    for (int i = 0; i < 150; i++) begin
      do_op(rand_op(), rand_op());
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'($urandom);
        idle(int'($urandom_range(0, 40)));
        in_valid = 1'b0;
      end
    end

    // in_valid held high with operands changing every cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 150; i++) begin
      opa = rand_op();
      opb = rand_op();
      idle(1);
    end
    in_valid = 1'b0;
    idle(35);

    // Reset in the middle of DIV aborts the operation.
    do_op(32'h3F800000, 32'h40400000);
    idle(10);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    do_op(32'h40C00000, 32'h40000000);
    idle(35);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
